ballot_gate: RTL and testbench
==============================

Name: ballot_gate

Overview:
- Sits between the three per-party button debouncers and the vote logger.
- Enforces one ballot per voter: the presiding officer arms a ballot, the voter casts exactly one vote, and the machine then locks until re-armed.
- Simultaneous presses are rejected as spoiled ballots, and unused ballots expire after a timeout.
- Its per-party grant pulses are the only vote-valid inputs the logger receives.

Parameters:
TIMEOUT_CYCLES, 1000, cycles an armed ballot waits for a vote before expiring (minimum 2)
HOLD_CYCLES, 10, lockout/acknowledge duration after a cast or spoiled ballot (minimum 1)
COUNT_W, 8, width of voter_count and spoiled_count

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
mode  input  1  0 = voting, 1 = display; voting is blocked when 1
officer_enable  input  1  single-cycle pulse from the presiding officer to arm one ballot
valid_vote_1  input  1  debounced single-cycle vote pulse, party 1
valid_vote_2  input  1  debounced single-cycle vote pulse, party 2
valid_vote_3  input  1  debounced single-cycle vote pulse, party 3
party1_grant  output  1  registered one-cycle accepted-vote pulse to the logger, party 1
party2_grant  output  1  same, party 2
party3_grant  output  1  same, party 3
ballot_ready  output  1  high while a ballot is armed (ARMED state)
vote_ack  output  1  high throughout HOLD after an accepted vote; drives the acknowledge LED
spoiled  output  1  registered one-cycle pulse when a ballot is spoiled
timeout_pulse  output  1  registered one-cycle pulse when an armed ballot expires
voter_count  output  COUNT_W  accepted ballots since reset; saturating
spoiled_count  output  COUNT_W  spoiled ballots since reset; saturating
state_dbg  output  2  encoding: IDLE=0, ARMED=1, HOLD=2; 3 unused and decodes to IDLE

Behaviour:
Reset (asynchronous, active-high):
- state=IDLE; timer=0.
- All 1-bit outputs 0; voter_count=0; spoiled_count=0.
- Assertion mid-ballot aborts the ballot with no grant.

All other logic is on the rising clock edge. All outputs are registered.

IDLE:
- ballot_ready=0.
- officer_enable=1 with mode=0 -> ARMED, timer=0.
- Vote inputs are ignored; they are dropped, not queued.

ARMED:
- ballot_ready=1; timer increments every cycle.
- Priority, evaluated in this order each edge:
  1. mode=1 -> IDLE. No grant, no spoil, no timeout pulse.
  2. Exactly one valid_vote_N high -> HOLD.
     - partyN_grant=1 for exactly one cycle, starting the cycle after the sampled input (latency 1).
     - voter_count+1; vote_ack=1; timer=0.
  3. Two or three valid_vote inputs high in the same cycle -> HOLD.
     - spoiled=1 for one cycle; spoiled_count+1; no grant.
     - vote_ack stays 0; timer=0.
  4. timer==TIMEOUT_CYCLES-1 with no vote -> IDLE; timeout_pulse=1 for one cycle.
- A vote on the expiry cycle is accepted; the vote wins over the timeout.
- officer_enable is ignored; it does not restart the timer.

HOLD:
- All vote inputs and officer_enable are ignored.
- timer increments; at timer==HOLD_CYCLES-1 -> IDLE and vote_ack=0.
- mode=1 -> IDLE next edge; vote_ack clears. A grant already issued is not retracted.
- vote_ack is high for exactly HOLD_CYCLES cycles after an accepted vote; it is 0 after a spoil.

Counters:
- Saturate at 2^COUNT_W-1 with no wrap. Grants still issue when voter_count is saturated.
- Counters are unaffected by mode.

Grant outputs:
- At most one partyN_grant is high in any cycle.
- Grants never assert in consecutive cycles without a fresh officer_enable and a new ARMED entry.
- Minimum spacing between grants: HOLD_CYCLES+2 cycles.

Test Plan:
1. Reset, then officer_enable, then valid_vote_2 pulse 3 cycles later.
   -> party2_grant high for 1 cycle, the cycle after the vote.
   -> voter_count=1; vote_ack high 5 cycles (HOLD_CYCLES=5), then state_dbg=0.
2. Armed ballot; valid_vote_1 and valid_vote_3 high in the same cycle.
   -> no grant; spoiled pulse; spoiled_count=1; vote_ack=0.
   -> A second valid_vote_1 during HOLD is ignored; voter_count stays 0.
3. TIMEOUT_CYCLES=20, arm and send no vote.
   -> timeout_pulse 20 cycles after arming; back in IDLE.
   -> A later valid_vote_3 produces no grant.
   -> Repeat with valid_vote_3 on cycle 19: grant issued, no timeout_pulse.
4. Arm, raise mode=1, then valid_vote_1.
   -> IDLE, no grant.
   -> officer_enable while mode=1 leaves state_dbg=0.
5. COUNT_W=2, cast 5 valid ballots.
   -> voter_count goes 1,2,3,3,3; all 5 grants issued.
6. Assert reset asynchronously mid-HOLD, between clock edges.
   -> Outputs and counters are 0 before the next edge; state_dbg=0.

Source files
------------

// File: rtl/ballot_gate.sv
// One-ballot-per-voter gate between the party button debouncers and the vote logger.
// An officer arms a ballot; a single press is granted, multiple presses spoil it, silence expires it.
module ballot_gate #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HOLD_CYCLES    = 10,
  parameter int COUNT_W        = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mode,
  input  logic               officer_enable,
  input  logic               valid_vote_1,
  input  logic               valid_vote_2,
  input  logic               valid_vote_3,
  output logic               party1_grant,
  output logic               party2_grant,
  output logic               party3_grant,
  output logic               ballot_ready,
  output logic               vote_ack,
  output logic               spoiled,
  output logic               timeout_pulse,
  output logic [COUNT_W-1:0] voter_count,
  output logic [COUNT_W-1:0] spoiled_count,
  output logic [1:0]         state_dbg
);

  localparam int TMAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  logic [TW-1:0]      r_timer;
  logic [2:0]         r_grant;
  logic               r_ready;
  logic               r_ack;
  logic               r_spoiled;
  logic               r_timeout;
  logic [COUNT_W-1:0] r_voter_count;
  logic [COUNT_W-1:0] r_spoiled_count;

  logic [2:0] w_votes;
  logic       w_one;
  logic       w_multi;

  assign w_votes = {valid_vote_3, valid_vote_2, valid_vote_1};
  assign w_one   = $onehot(w_votes);
  assign w_multi = (|w_votes) && !w_one;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_timer         <= '0;
      r_grant         <= '0;
      r_ready         <= 1'b0;
      r_ack           <= 1'b0;
      r_spoiled       <= 1'b0;
      r_timeout       <= 1'b0;
      r_voter_count   <= '0;
      r_spoiled_count <= '0;
    end else begin
      r_grant   <= '0;
      r_spoiled <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_ARMED: begin
          // A vote arriving on the expiry edge wins over the timeout.
          if (mode) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
          end else if (w_one) begin
            r_state <= S_HOLD;
            r_ready <= 1'b0;
            r_grant <= w_votes;
            r_ack   <= 1'b1;
            r_timer <= '0;
            if (r_voter_count != '1) r_voter_count <= r_voter_count + 1'b1;
          end else if (w_multi) begin
            r_state   <= S_HOLD;
            r_ready   <= 1'b0;
            r_spoiled <= 1'b1;
            r_timer   <= '0;
            if (r_spoiled_count != '1) r_spoiled_count <= r_spoiled_count + 1'b1;
          end else if (r_timer == TO_LAST) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_HOLD: begin
          if (mode || r_timer == HOLD_LAST) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          // Unused encoding behaves as IDLE and falls back to it.
          if (officer_enable && !mode) begin
            r_state <= S_ARMED;
            r_ready <= 1'b1;
            r_timer <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign party1_grant  = r_grant[0];
  assign party2_grant  = r_grant[1];
  assign party3_grant  = r_grant[2];
  assign ballot_ready  = r_ready;
  assign vote_ack      = r_ack;
  assign spoiled       = r_spoiled;
  assign timeout_pulse = r_timeout;
  assign voter_count   = r_voter_count;
  assign spoiled_count = r_spoiled_count;
  assign state_dbg     = r_state;

endmodule

// File: tb/tb_ballot_gate.sv
// Directed bench for ballot_gate with TIMEOUT_CYCLES=20, HOLD_CYCLES=5, COUNT_W=2.
module tb_ballot_gate;
  logic       clock = 1'b0;
  logic       reset;
  logic       mode, officer_enable, valid_vote_1, valid_vote_2, valid_vote_3;
  logic       party1_grant, party2_grant, party3_grant;
  logic       ballot_ready, vote_ack, spoiled, timeout_pulse;
  logic [1:0] voter_count, spoiled_count, state_dbg;

  int checks = 0;
  int errors = 0;

  ballot_gate #(.TIMEOUT_CYCLES(20), .HOLD_CYCLES(5), .COUNT_W(2)) dut (
    .clock(clock), .reset(reset), .mode(mode), .officer_enable(officer_enable),
    .valid_vote_1(valid_vote_1), .valid_vote_2(valid_vote_2), .valid_vote_3(valid_vote_3),
    .party1_grant(party1_grant), .party2_grant(party2_grant), .party3_grant(party3_grant),
    .ballot_ready(ballot_ready), .vote_ack(vote_ack), .spoiled(spoiled),
    .timeout_pulse(timeout_pulse), .voter_count(voter_count), .spoiled_count(spoiled_count),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] grants();
    return {party3_grant, party2_grant, party1_grant};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    mode = 1'b0; officer_enable = 1'b0;
    valid_vote_1 = 1'b0; valid_vote_2 = 1'b0; valid_vote_3 = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic arm();
    officer_enable = 1'b1;
    tick();
    officer_enable = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // 1: single valid vote
    do_reset();
    chk("rst_state", state_dbg, 0);
    chk("rst_vcnt", voter_count, 0);
    chk("rst_scnt", spoiled_count, 0);
    chk("rst_outs", {grants(), ballot_ready, vote_ack, spoiled, timeout_pulse}, 0);
    arm();
    chk("t1_ready", ballot_ready, 1);
    chk("t1_state_armed", state_dbg, 1);
    tick(); tick();
    chk("t1_no_early_grant", grants(), 0);
    valid_vote_2 = 1'b1;
    tick();
    valid_vote_2 = 1'b0;
    chk("t1_grant2", grants(), 3'b010);
    chk("t1_vcnt", voter_count, 1);
    chk("t1_ack", vote_ack, 1);
    chk("t1_state_hold", state_dbg, 2);
    chk("t1_ready_low", ballot_ready, 0);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("t1_grant_one_cycle", grants(), 0);
      chk("t1_ack_held", vote_ack, 1);
    end
    tick();
    chk("t1_ack_drop", vote_ack, 0);
    chk("t1_idle", state_dbg, 0);

    // 2: spoiled ballot
    do_reset();
    arm();
    valid_vote_1 = 1'b1; valid_vote_3 = 1'b1;
    tick();
    valid_vote_1 = 1'b0; valid_vote_3 = 1'b0;
    chk("t2_no_grant", grants(), 0);
    chk("t2_spoiled", spoiled, 1);
    chk("t2_scnt", spoiled_count, 1);
    chk("t2_ack", vote_ack, 0);
    chk("t2_state_hold", state_dbg, 2);
    valid_vote_1 = 1'b1;
    tick();
    valid_vote_1 = 1'b0;
    chk("t2_spoil_pulse", spoiled, 0);
    chk("t2_hold_vote_ignored", grants(), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("t2_vcnt", voter_count, 0);
    chk("t2_idle", state_dbg, 0);

    // 3: timeout, then vote on the expiry edge
    do_reset();
    arm();
    for (int i = 1; i < 20; i++) begin
      tick();
      chk("t3_no_early_timeout", timeout_pulse, 0);
    end
    chk("t3_still_armed", state_dbg, 1);
    tick();
    chk("t3_timeout", timeout_pulse, 1);
    chk("t3_idle", state_dbg, 0);
    chk("t3_ready_low", ballot_ready, 0);
    valid_vote_3 = 1'b1;
    tick();
    valid_vote_3 = 1'b0;
    chk("t3_timeout_pulse_one", timeout_pulse, 0);
    chk("t3_late_vote", grants(), 0);
    arm();
    for (int i = 1; i < 20; i++) tick();
    valid_vote_3 = 1'b1;
    tick();
    valid_vote_3 = 1'b0;
    chk("t3_edge_grant", grants(), 3'b100);
    chk("t3_edge_no_timeout", timeout_pulse, 0);
    chk("t3_edge_vcnt", voter_count, 1);

    // 4: display mode aborts ballot and blocks arming
    do_reset();
    arm();
    mode = 1'b1;
    tick();
    chk("t4_mode_idle", state_dbg, 0);
    chk("t4_mode_ready", ballot_ready, 0);
    valid_vote_1 = 1'b1;
    tick();
    valid_vote_1 = 1'b0;
    chk("t4_no_grant", grants(), 0);
    officer_enable = 1'b1;
    tick();
    officer_enable = 1'b0;
    chk("t4_arm_blocked", state_dbg, 0);
    mode = 1'b0;
    arm();
    valid_vote_1 = 1'b1;
    tick();
    valid_vote_1 = 1'b0;
    mode = 1'b1;
    tick();
    mode = 1'b0;
    chk("t4_hold_abort", state_dbg, 0);
    chk("t4_hold_ack", vote_ack, 0);
    chk("t4_hold_vcnt", voter_count, 1);

    // 5: saturating voter count, grants continue
    do_reset();
    for (int b = 0; b < 5; b++) begin
      arm();
      valid_vote_1 = (b % 3 == 0);
      valid_vote_2 = (b % 3 == 1);
      valid_vote_3 = (b % 3 == 2);
      tick();
      valid_vote_1 = 1'b0; valid_vote_2 = 1'b0; valid_vote_3 = 1'b0;
      chk("t5_grant", grants(), 3'b001 << (b % 3));
      chk("t5_vcnt", voter_count, exp_cnt[b]);
      for (int i = 0; i < 5; i++) tick();
    end

    // 6: asynchronous reset mid-HOLD
    arm();
    valid_vote_2 = 1'b1;
    tick();
    valid_vote_2 = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("t6_state", state_dbg, 0);
    chk("t6_vcnt", voter_count, 0);
    chk("t6_scnt", spoiled_count, 0);
    chk("t6_outs", {grants(), ballot_ready, vote_ack, spoiled, timeout_pulse}, 0);
    #1 reset = 1'b0;
    tick();
    chk("t6_after", state_dbg, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
